// File: rtl/fifo_wr_arbiter_if.sv
// Requester, FIFO write-port and status signals of fifo_wr_arbiter.
// The master modport is the arbiter side, the slave modport the producer/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 4
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      full;
    logic                      w_en;
    logic [DATA_W-1:0]         w_data;
    logic [NUM_REQ-1:0]        ack;
    logic [ID_W-1:0]           grant_id;
    logic                      busy;

    modport master (
        input  req, req_data, full,
        output w_en, w_data, ack, grant_id, busy
    );

    modport slave (
        output req, req_data, full,
        input  w_en, w_data, ack, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ requesters (w_clk domain).
// Define FIFO_ARB_BURST_EN to let a grant hold for up to BURST_LEN accepted words.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic              i_w_clk,
    input  logic              i_w_rst_n,
    fifo_wr_arbiter_if.master io_bus
);
    localparam int unsigned ID_W   = $clog2(NUM_REQ);
    localparam int unsigned BEAT_W = 4;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("fifo_wr_arbiter: NUM_REQ must be within 2..8");
    end
    if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_burst_len
        $error("fifo_wr_arbiter: BURST_LEN must be within 1..15");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ID_W-1:0] r_grant_id;
    logic [ID_W-1:0] w_grant_id_nxt;
    logic [ID_W-1:0] r_rr_last;
    logic [ID_W-1:0] w_rr_last_nxt;

    logic            w_req_g;
    logic            w_wr;
    logic            w_last_beat;
    logic            w_end;
    logic            w_pick_vld;
    logic [ID_W-1:0] w_pick_id;
    logic [ID_W-1:0] w_scan_base;

`ifdef FIFO_ARB_BURST_EN
    localparam logic [BEAT_W-1:0] BURST_LIMIT = BEAT_W'(BURST_LEN);

    logic [BEAT_W-1:0] r_beat_cnt;
    logic [BEAT_W-1:0] w_beat_cnt_nxt;
    logic [BEAT_W-1:0] w_beat_inc;
`endif

    // First set bit of vec scanning base+1, base+2, ... modulo NUM_REQ; base itself is visited last.
    function automatic logic [ID_W:0] rr_scan(input logic [ID_W-1:0]    base,
                                              input logic [NUM_REQ-1:0] vec);
        logic            found;
        logic [ID_W-1:0] idx;
        int unsigned     pos;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            pos = 32'(base) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!found && vec[ID_W'(pos)]) begin
                found = 1'b1;
                idx   = ID_W'(pos);
            end
        end
        return {found, idx};
    endfunction

    // Write qualifier; reset gates it so a word presented during reset is never acked.
    assign w_req_g = io_bus.req[r_grant_id];
    assign w_wr    = (r_state == S_GRANT) & w_req_g & ~io_bus.full & i_w_rst_n;

`ifdef FIFO_ARB_BURST_EN
    assign w_beat_inc  = r_beat_cnt + BEAT_W'(1);
    assign w_last_beat = w_wr & (w_beat_inc == BURST_LIMIT);
`else
    assign w_last_beat = w_wr;
`endif

    assign w_end = ~w_req_g | w_last_beat;

    // Holder's own bit is scanned last, so it only regains the grant when nobody else asks.
    assign w_scan_base             = (r_state == S_IDLE) ? r_rr_last : r_grant_id;
    assign {w_pick_vld, w_pick_id} = rr_scan(w_scan_base, io_bus.req);

    always_ff @(posedge i_w_clk) begin
        if (!i_w_rst_n) begin
            r_state    <= S_IDLE;
            r_grant_id <= '0;
            r_rr_last  <= ID_W'(NUM_REQ - 1);
`ifdef FIFO_ARB_BURST_EN
            r_beat_cnt <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_rr_last  <= w_rr_last_nxt;
`ifdef FIFO_ARB_BURST_EN
            r_beat_cnt <= w_beat_cnt_nxt;
`endif
        end
    end

    // Next state: arbitrate from IDLE, or re-arbitrate in the same edge a grant ends.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_id_nxt = r_grant_id;
        w_rr_last_nxt  = r_rr_last;
`ifdef FIFO_ARB_BURST_EN
        w_beat_cnt_nxt = r_beat_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt    = S_GRANT;
                    w_grant_id_nxt = w_pick_id;
                    w_rr_last_nxt  = w_pick_id;
`ifdef FIFO_ARB_BURST_EN
                    w_beat_cnt_nxt = '0;
`endif
                end
            end
            S_GRANT: begin
                if (w_end) begin
                    if (w_pick_vld) begin
                        w_grant_id_nxt = w_pick_id;
                        w_rr_last_nxt  = w_pick_id;
`ifdef FIFO_ARB_BURST_EN
                        w_beat_cnt_nxt = '0;
`endif
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
`ifdef FIFO_ARB_BURST_EN
                else if (w_wr) begin
                    w_beat_cnt_nxt = w_beat_inc;
                end
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Write-data mux: granted requester's word in GRANT, zero in IDLE.
    always_comb begin
        io_bus.w_data = '0;
        if (r_state == S_GRANT) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (r_grant_id == ID_W'(i)) begin
                    io_bus.w_data = io_bus.req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        io_bus.ack             = '0;
        io_bus.ack[r_grant_id] = w_wr;
    end

    assign io_bus.w_en     = w_wr;
    assign io_bus.grant_id = r_grant_id;
    assign io_bus.busy     = (r_state == S_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=4, BURST_LEN=4); expectations follow FIFO_ARB_BURST_EN.
module tb_fifo_wr_arbiter;
    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned DATA_W    = 4;
    localparam int unsigned BURST_LEN = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    int               checks   = 0;
    int               failures = 0;
    logic [DATA_W-1:0] dat [NUM_REQ];
    logic [1:0]       g;

    fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .BURST_LEN(BURST_LEN)
    ) dut (
        .i_w_clk  (clk),
        .i_w_rst_n(rst_n),
        .io_bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected observation vector {w_en, ack, grant_id, busy, w_data}.
    function automatic logic [11:0] ev(input logic wen, input logic [1:0] gid,
                                       input logic busy, input logic [3:0] wd);
        logic [3:0] ack;
        ack = wen ? (4'b0001 << gid) : 4'b0000;
        return {wen, ack, gid, busy, wd};
    endfunction

    // Drive one cycle's inputs after the falling edge, then compare the combinational outputs.
    task automatic step(input string tag, input logic rs, input logic [3:0] rq,
                        input logic fl, input logic [11:0] exp);
        logic [11:0] obs;
        @(negedge clk);
        rst_n    = rs;
        bus.req  = rq;
        bus.full = fl;
        #1;
        obs = {bus.w_en, bus.ack, bus.grant_id, bus.busy, bus.w_data};
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        dat[0] = 4'h1;
        dat[1] = 4'hA;
        dat[2] = 4'h5;
        dat[3] = 4'hC;
        bus.req_data = {dat[3], dat[2], dat[1], dat[0]};
        rst_n    = 1'b0;
        bus.req  = 4'b1111;
        bus.full = 1'b0;

        // Reset with all requesting, then release: first ack to r0 one cycle later.
        step("reset", 1'b0, 4'b1111, 1'b0, ev(1'b0, 2'd0, 1'b0, 4'h0));
        step("release", 1'b1, 4'b1111, 1'b0, ev(1'b0, 2'd0, 1'b0, 4'h0));
        for (int i = 0; i < 8; i++) begin
`ifdef FIFO_ARB_BURST_EN
            g = 2'(i / 4);
`else
            g = 2'(i % 4);
`endif
            step("rr_all", 1'b1, 4'b1111, 1'b0, ev(1'b1, g, 1'b1, dat[g]));
        end

        // Only r1 left: old holder sees req low (bubble), then r1 is granted.
`ifdef FIFO_ARB_BURST_EN
        g = 2'd2;
`else
        g = 2'd0;
`endif
        step("handoff", 1'b1, 4'b0010, 1'b0, ev(1'b0, g, 1'b1, dat[g]));
        step("r1_word", 1'b1, 4'b0010, 1'b0, ev(1'b1, 2'd1, 1'b1, 4'hA));
        for (int i = 0; i < 3; i++) begin
            step("full_stall", 1'b1, 4'b0010, 1'b1, ev(1'b0, 2'd1, 1'b1, 4'hA));
        end
        step("after_full", 1'b1, 4'b0010, 1'b0, ev(1'b1, 2'd1, 1'b1, 4'hA));
        for (int i = 0; i < 4; i++) begin
            step("single_r1", 1'b1, 4'b0010, 1'b0, ev(1'b1, 2'd1, 1'b1, 4'hA));
        end

        // r3 requests under full and abandons; nothing else asks, so back to IDLE.
        step("abandon_a", 1'b1, 4'b1000, 1'b1, ev(1'b0, 2'd1, 1'b1, 4'hA));
        step("abandon_b", 1'b1, 4'b1000, 1'b1, ev(1'b0, 2'd3, 1'b1, 4'hC));
        step("abandon_c", 1'b1, 4'b0000, 1'b1, ev(1'b0, 2'd3, 1'b1, 4'hC));
        step("abandon_idle", 1'b1, 4'b0000, 1'b0, ev(1'b0, 2'd3, 1'b0, 4'h0));

        // r3 abandons again while r0 waits: r0 is granted next.
        step("abn2_idle", 1'b1, 4'b1000, 1'b1, ev(1'b0, 2'd3, 1'b0, 4'h0));
        step("abn2_hold", 1'b1, 4'b1001, 1'b1, ev(1'b0, 2'd3, 1'b1, 4'hC));
        step("abn2_drop", 1'b1, 4'b0001, 1'b0, ev(1'b0, 2'd3, 1'b1, 4'hC));
        step("abn2_r0", 1'b1, 4'b0001, 1'b0, ev(1'b1, 2'd0, 1'b1, 4'h1));
        step("abn2_end", 1'b1, 4'b0000, 1'b0, ev(1'b0, 2'd0, 1'b1, 4'h1));

        // Reset mid-grant: the word presented during reset is not acked.
        step("mr_idle", 1'b1, 4'b0100, 1'b0, ev(1'b0, 2'd0, 1'b0, 4'h0));
        step("mr_write", 1'b1, 4'b0100, 1'b0, ev(1'b1, 2'd2, 1'b1, 4'h5));
        step("mr_rst", 1'b0, 4'b0100, 1'b0, ev(1'b0, 2'd2, 1'b1, 4'h5));
        step("mr_rst2", 1'b0, 4'b0100, 1'b0, ev(1'b0, 2'd0, 1'b0, 4'h0));
        step("mr_release", 1'b1, 4'b0000, 1'b0, ev(1'b0, 2'd0, 1'b0, 4'h0));

`ifdef FIFO_ARB_BURST_EN
        // r0 and r2 with six words each: r0x4, r2x4, r0x2, r2x2.
        step("b_idle", 1'b1, 4'b0101, 1'b0, ev(1'b0, 2'd0, 1'b0, 4'h0));
        for (int i = 0; i < 4; i++) step("b_r0a", 1'b1, 4'b0101, 1'b0, ev(1'b1, 2'd0, 1'b1, 4'h1));
        for (int i = 0; i < 4; i++) step("b_r2a", 1'b1, 4'b0101, 1'b0, ev(1'b1, 2'd2, 1'b1, 4'h5));
        for (int i = 0; i < 2; i++) step("b_r0b", 1'b1, 4'b0101, 1'b0, ev(1'b1, 2'd0, 1'b1, 4'h1));
        step("b_r0_done", 1'b1, 4'b0100, 1'b0, ev(1'b0, 2'd0, 1'b1, 4'h1));
        for (int i = 0; i < 2; i++) step("b_r2b", 1'b1, 4'b0100, 1'b0, ev(1'b1, 2'd2, 1'b1, 4'h5));
        step("b_r2_done", 1'b1, 4'b0000, 1'b0, ev(1'b0, 2'd2, 1'b1, 4'h5));
        step("b_idle_end", 1'b1, 4'b0000, 1'b0, ev(1'b0, 2'd2, 1'b0, 4'h0));
`else
        // r0 and r2 alternate one word per grant.
        step("a_idle", 1'b1, 4'b0101, 1'b0, ev(1'b0, 2'd0, 1'b0, 4'h0));
        for (int i = 0; i < 2; i++) begin
            step("a_r0", 1'b1, 4'b0101, 1'b0, ev(1'b1, 2'd0, 1'b1, 4'h1));
            step("a_r2", 1'b1, 4'b0101, 1'b0, ev(1'b1, 2'd2, 1'b1, 4'h5));
        end
        step("a_drop", 1'b1, 4'b0000, 1'b0, ev(1'b0, 2'd0, 1'b1, 4'h1));
        step("a_idle_end", 1'b1, 4'b0000, 1'b0, ev(1'b0, 2'd0, 1'b0, 4'h0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
